cross_clock_irrevocable_example: RTL and testbench



---
 rtl/cross_clock_irrevocable_example_if.sv | 20 ++
 rtl/cross_clock_irrevocable_example.sv | 72 +++++++
 tb/tb_cross_clock_irrevocable_example.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cross_clock_irrevocable_example_if.sv
// cross_clock_irrevocable_example_if: observation bundle for the source and sink handshakes
// master: driven by the example block; slave: observer (bench or monitor)
interface cross_clock_irrevocable_example_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] io_src_count;
    logic                  io_src_valid;
    logic                  io_src_ready;
    logic [DATA_WIDTH-1:0] io_dst_count;
    logic                  io_dst_valid;
    logic                  io_dst_ready;
    modport master (
        output io_src_count, io_src_valid, io_src_ready,
        output io_dst_count, io_dst_valid, io_dst_ready
    );
    modport slave (
        input io_src_count, io_src_valid, io_src_ready,
        input io_dst_count, io_dst_valid, io_dst_ready
    );
endinterface

// File: rtl/cross_clock_irrevocable_example.sv
// cross_clock_irrevocable_example: count source -> gray-pointer crossing FIFO -> backpressured sink
// io_clock: shared clock for both FIFO sides; io_reset: async active-low reset
// obs: source handshake (count/valid/ready) and sink handshake (count/valid/ready)
module cross_clock_irrevocable_example #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                                     io_clock,
    input  logic                                     io_reset,
    cross_clock_irrevocable_example_if.master        obs
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] src_count_q, src_count_d;
    logic                  src_valid_q;
    logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]           wgray_q, rgray_q;
    logic [AW:0]           wsync1_q, wsync2_q, rsync1_q, rsync2_q;
    logic [1:0]            phase_q;
    logic                  full, empty, wr_en, rd_en, snk_ready;
    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction
    // Sink is held not-ready while reset is asserted, then idles one cycle in four
    assign snk_ready = io_reset && (phase_q != 2'd3);
    always_comb begin
        // Full: write pointer has lapped the (lagging) read pointer by exactly DEPTH
        full        = wgray_q == {~rsync2_q[AW:AW-1], rsync2_q[AW-2:0]};
        empty       = wsync2_q == rgray_q;
        wr_en       = src_valid_q && !full;
        rd_en       = !empty && snk_ready;
        wptr_d      = wptr_q + {{AW{1'b0}}, wr_en};
        rptr_d      = rptr_q + {{AW{1'b0}}, rd_en};
        src_count_d = src_count_q + {{(DATA_WIDTH-1){1'b0}}, wr_en};
    end
    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            src_count_q <= '0;
            src_valid_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            wgray_q     <= '0;
            rgray_q     <= '0;
            wsync1_q    <= '0;
            wsync2_q    <= '0;
            rsync1_q    <= '0;
            rsync2_q    <= '0;
            phase_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            src_count_q <= src_count_d;
            src_valid_q <= 1'b1;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            // Gray copies track the next pointer so they change in the same cycle as the binary pointer
            wgray_q     <= gray(wptr_d);
            rgray_q     <= gray(rptr_d);
            wsync1_q    <= wgray_q;
            wsync2_q    <= wsync1_q;
            rsync1_q    <= rgray_q;
            rsync2_q    <= rsync1_q;
            phase_q     <= phase_q + 2'd1;
            if (wr_en) mem_q[wptr_q[AW-1:0]] <= src_count_q;
        end
    end
    assign obs.io_src_count = src_count_q;
    assign obs.io_src_valid = src_valid_q;
    assign obs.io_src_ready = !full;
    assign obs.io_dst_count = mem_q[rptr_q[AW-1:0]];
    assign obs.io_dst_valid = !empty;
    assign obs.io_dst_ready = snk_ready;
endmodule

// File: tb/tb_cross_clock_irrevocable_example.sv
// tb_cross_clock_irrevocable_example: directed checks of the count stream through the crossing FIFO
module tb_cross_clock_irrevocable_example;
    logic       io_clock = 1'b0;
    logic       io_reset = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] exp_src  = 8'd0;
    logic [7:0] exp_dst  = 8'd0;

    cross_clock_irrevocable_example_if #(.DATA_WIDTH(8)) obs();
    cross_clock_irrevocable_example #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .io_clock(io_clock),
        .io_reset(io_reset),
        .obs     (obs)
    );

    always #5 io_clock = ~io_clock;

    // Cycle k is the interval after the k-th rising edge since reset release; sample 1 time unit in
    task automatic step();
        @(posedge io_clock);
        #1;
        cyc++;
    endtask

    task automatic release_reset();
        @(negedge io_clock);
        io_reset = 1'b1;
        cyc      = 0;
        exp_src  = 8'd0;
        exp_dst  = 8'd0;
    endtask

    task automatic test_reset();
        io_reset = 1'b0;
        repeat (10) @(posedge io_clock);
        #1;
        n_checks++; if (obs.io_src_count !== 8'd0) $display("FAIL reset_src_count: got %0h want 0", obs.io_src_count);
        else ; if (obs.io_src_count !== 8'd0) n_fail++;
        n_checks++; if (obs.io_src_valid !== 1'b0) begin n_fail++; $display("FAIL reset_src_valid: got %b want 0", obs.io_src_valid); end
        n_checks++; if (obs.io_src_ready !== 1'b1) begin n_fail++; $display("FAIL reset_src_ready: got %b want 1", obs.io_src_ready); end
        n_checks++; if (obs.io_dst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dst_valid: got %b want 0", obs.io_dst_valid); end
        n_checks++; if (obs.io_dst_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dst_ready: got %b want 0", obs.io_dst_ready); end
        n_checks++; if (obs.io_dst_count !== 8'd0) begin n_fail++; $display("FAIL reset_dst_count: got %0h want 0", obs.io_dst_count); end
        release_reset();
        #1;
        n_checks++; if (obs.io_src_valid !== 1'b0) begin n_fail++; $display("FAIL rel_src_valid_c0: got %b want 0", obs.io_src_valid); end
        n_checks++; if (obs.io_dst_ready !== 1'b1) begin n_fail++; $display("FAIL rel_dst_ready_c0: got %b want 1", obs.io_dst_ready); end
        step();
        n_checks++; if (obs.io_src_valid !== 1'b1) begin n_fail++; $display("FAIL rel_src_valid_c1: got %b want 1", obs.io_src_valid); end
        n_checks++; if (obs.io_src_count !== 8'd0) begin n_fail++; $display("FAIL rel_src_count_c1: got %0h want 0", obs.io_src_count); end
    endtask

    // Entered at cycle 1 (first source transfer); leaves at cycle 4 with its transfers accounted
    task automatic test_first_word();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            n_checks++;
            if (obs.io_dst_valid !== (k == 3)) begin
                n_fail++; $display("FAIL first_word_valid_c%0d: got %b want %b", cyc, obs.io_dst_valid, k == 3);
            end
            if (k == 3) begin
                n_checks++;
                if (obs.io_dst_count !== 8'd0) begin n_fail++; $display("FAIL first_word_count: got %0h want 0", obs.io_dst_count); end
            end
            if (obs.io_src_valid && obs.io_src_ready) begin
                n_checks++;
                if (obs.io_src_count !== exp_src) begin n_fail++; $display("FAIL first_src_count_c%0d: got %0h want %0h", cyc, obs.io_src_count, exp_src); end
                exp_src++;
            end
            if (obs.io_dst_valid && obs.io_dst_ready) exp_dst++;
        end
    endtask

    task automatic test_stream(input int n, input bit check_rate);
        int         n_wr = 0;
        int         n_rd = 0;
        logic       hold_pend = 1'b0;
        logic [7:0] hold_val = 8'd0;
        for (int k = 0; k < n; k++) begin
            step();
            if (hold_pend) begin
                n_checks++;
                if (obs.io_dst_valid !== 1'b1 || obs.io_dst_count !== hold_val) begin
                    n_fail++; $display("FAIL stall_hold_c%0d: got v=%b d=%0h want v=1 d=%0h", cyc, obs.io_dst_valid, obs.io_dst_count, hold_val);
                end
            end
            n_checks++;
            if (obs.io_dst_ready !== ((cyc % 4) != 3)) begin
                n_fail++; $display("FAIL dst_ready_pattern_c%0d: got %b want %b", cyc, obs.io_dst_ready, (cyc % 4) != 3);
            end
            n_checks++;
            if (obs.io_src_valid !== 1'b1) begin n_fail++; $display("FAIL src_valid_c%0d: got %b want 1", cyc, obs.io_src_valid); end
            hold_pend = obs.io_dst_valid && !obs.io_dst_ready;
            hold_val  = obs.io_dst_count;
            if (obs.io_dst_valid && obs.io_dst_ready) begin
                n_checks++;
                if (obs.io_dst_count !== exp_dst) begin n_fail++; $display("FAIL dst_seq_c%0d: got %0h want %0h", cyc, obs.io_dst_count, exp_dst); end
                exp_dst++;
                n_rd++;
            end
            if (obs.io_src_valid && obs.io_src_ready) begin
                n_checks++;
                if (obs.io_src_count !== exp_src) begin n_fail++; $display("FAIL src_seq_c%0d: got %0h want %0h", cyc, obs.io_src_count, exp_src); end
                exp_src++;
                n_wr++;
            end
        end
        if (check_rate) begin
            n_checks++;
            if (n_rd != (n * 3) / 4 && n_rd != (n * 3) / 4 - 1) begin
                n_fail++; $display("FAIL sink_rate: got %0d reads want about %0d", n_rd, (n * 3) / 4);
            end
            n_checks++;
            if (n_wr < (n * 3) / 4 - 12 || n_wr > (n * 3) / 4 + 12) begin
                n_fail++; $display("FAIL source_rate: got %0d writes want %0d +/-12", n_wr, (n * 3) / 4);
            end
        end
    endtask

    task automatic test_full();
        io_reset = 1'b0;
        repeat (3) @(posedge io_clock);
        force dut.snk_ready = 1'b0;
        release_reset();
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++;
            if (!(obs.io_src_valid && obs.io_src_ready) || obs.io_src_count !== exp_src) begin
                n_fail++; $display("FAIL full_fill_c%0d: got v=%b r=%b d=%0h want v=1 r=1 d=%0h", cyc, obs.io_src_valid, obs.io_src_ready, obs.io_src_count, exp_src);
            end
            exp_src++;
        end
        for (int k = 9; k <= 15; k++) begin
            step();
            n_checks++;
            if (obs.io_src_ready !== 1'b0 || obs.io_src_valid !== 1'b1 || obs.io_src_count !== 8'd8) begin
                n_fail++; $display("FAIL full_hold_c%0d: got r=%b v=%b d=%0h want r=0 v=1 d=8", cyc, obs.io_src_ready, obs.io_src_valid, obs.io_src_count);
            end
            n_checks++;
            if (obs.io_dst_valid !== 1'b1 || obs.io_dst_count !== 8'd0 || obs.io_dst_ready !== 1'b0) begin
                n_fail++; $display("FAIL full_head_c%0d: got v=%b d=%0h rdy=%b want v=1 d=0 rdy=0", cyc, obs.io_dst_valid, obs.io_dst_count, obs.io_dst_ready);
            end
        end
        step();
        release dut.snk_ready;
        #1;
        n_checks++;
        if (obs.io_dst_ready !== 1'b1 || obs.io_dst_valid !== 1'b1 || obs.io_dst_count !== 8'd0) begin
            n_fail++; $display("FAIL full_first_read: got rdy=%b v=%b d=%0h want 1 1 0", obs.io_dst_ready, obs.io_dst_valid, obs.io_dst_count);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs.io_src_ready !== (k == 3)) begin
                n_fail++; $display("FAIL full_free_lag_c%0d: got %b want 0", cyc, obs.io_src_ready);
            end
            step();
        end
        n_checks++;
        if (obs.io_src_ready !== 1'b1 || obs.io_src_count !== 8'd8) begin
            n_fail++; $display("FAIL full_free_c%0d: got r=%b d=%0h want r=1 d=8", cyc, obs.io_src_ready, obs.io_src_count);
        end
        repeat (6) step();
    endtask

    task automatic test_async_reset();
        n_checks++;
        if (obs.io_src_count === 8'd0) begin n_fail++; $display("FAIL async_pre_count: got 0 want nonzero"); end
        @(posedge io_clock);
        #3;
        io_reset = 1'b0;
        #1;
        n_checks++;
        if (obs.io_src_count !== 8'd0 || obs.io_src_valid !== 1'b0 || obs.io_src_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_src_clear: got d=%0h v=%b r=%b want 0 0 1", obs.io_src_count, obs.io_src_valid, obs.io_src_ready);
        end
        n_checks++;
        if (obs.io_dst_count !== 8'd0 || obs.io_dst_valid !== 1'b0 || obs.io_dst_ready !== 1'b0) begin
            n_fail++; $display("FAIL async_dst_clear: got d=%0h v=%b r=%b want 0 0 0", obs.io_dst_count, obs.io_dst_valid, obs.io_dst_ready);
        end
        repeat (3) @(posedge io_clock);
        release_reset();
        step();
        n_checks++;
        if (obs.io_src_valid !== 1'b1 || obs.io_src_count !== 8'd0) begin
            n_fail++; $display("FAIL async_restart: got v=%b d=%0h want v=1 d=0", obs.io_src_valid, obs.io_src_count);
        end
        test_first_word();
        test_stream(80, 1'b0);
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_stream(1000, 1'b1);
        test_full();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end
endmodule
